// File: rtl/icache_port_a.sv
// Direct-mapped, read-only instruction cache responding on fetch port A.
// Hits answer in the request cycle; misses fetch a whole 256-bit line from pmem.
module icache_port_a #(
    parameter int s_index  = 3,
    parameter int s_offset = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         read_a,
    input  logic [31:0]  address_a,
    output logic [31:0]  rdata_a,
    output logic         resp_a,
    input  logic         flush,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    input  logic         hit_count_reset,
    input  logic         miss_count_reset
);
    localparam int NLINES = 2 ** s_index;
    localparam int TAG_W  = 32 - s_index - s_offset;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NLINES-1:0]   r_valid;
    logic [TAG_W-1:0]    r_tag  [NLINES];
    logic [255:0]        r_data [NLINES];
    logic [31:0]         r_fill_addr;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [s_index-1:0]  w_index;
    logic [s_index-1:0]  w_fill_index;
    logic [TAG_W-1:0]    w_tag;
    logic [TAG_W-1:0]    w_fill_tag;
    logic [2:0]          w_word;
    logic                w_hit;
    logic                w_start_fill;
    logic                w_install;
    logic                w_resp;
    logic [31:0]         w_rdata;
    logic [31:0]         w_hit_word;
    logic                w_unused;

    assign w_index      = address_a[s_index+s_offset-1:s_offset];
    assign w_tag        = address_a[31:s_index+s_offset];
    assign w_word       = address_a[s_offset-1:2];
    assign w_fill_index = r_fill_addr[s_index+s_offset-1:s_offset];
    assign w_fill_tag   = r_fill_addr[31:s_index+s_offset];
    assign w_unused     = ^address_a[1:0];

    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_hit_word = r_data[w_index][{w_word, 5'b0} +: 32];

    always_comb begin
        w_state_nxt  = r_state;
        w_resp       = 1'b0;
        w_rdata      = '0;
        w_start_fill = 1'b0;
        w_install    = 1'b0;
        case (r_state)
            IDLE: begin
                if (read_a) begin
                    if (w_hit) begin
                        w_resp  = 1'b1;
                        w_rdata = w_hit_word;
                    end else begin
                        w_start_fill = 1'b1;
                        w_state_nxt  = FILL;
                    end
                end
            end
            FILL: begin
                // pmem_resp only matters here; outside FILL it is ignored
                if (pmem_resp) begin
                    w_install   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_fill_addr <= '0;
            r_valid     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_fill)
                r_fill_addr <= {address_a[31:s_offset], {s_offset{1'b0}}};
            // a flush coinciding with the install leaves the new line invalid
            if (flush)
                r_valid <= '0;
            else if (w_install)
                r_valid[w_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= pmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (hit_count_reset)
                r_hit_count <= '0;
            else if (w_resp)
                r_hit_count <= r_hit_count + 32'd1;
            if (miss_count_reset)
                r_miss_count <= '0;
            else if (w_start_fill)
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign resp_a       = w_resp;
    assign rdata_a      = w_rdata;
    assign pmem_read    = (r_state == FILL);
    assign pmem_address = r_fill_addr;
    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;

endmodule
